set_region_counter: RTL and testbench

Parametrised grid-coverage counter: given NC circles (centre, radius) on a GRID×GRID lattice (coordinates 1..GRID), scans every lattice point and counts those satisfying a selectable coverage rule over a masked subset of circles. Successor of the fixed 8×8, 3-circle candidate counter. Adds a parametrised grid, circle count and coordinate width, a per-job circle mask, a threshold K, and a pipelined datapath. Sits behind the job-issue logic as a single-job-at-a-time accelerator.

---
 rtl/set_region_counter_pkg.sv | 31 +++
 rtl/set_region_counter_if.sv | 24 ++
 rtl/set_region_counter_circle.sv | 38 +++
 rtl/set_region_counter.sv | 125 ++++++++++++
 tb/tb_set_region_counter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/set_region_counter_pkg.sv
// Shared types and width/field helpers for the grid-coverage counter.
package set_pkg;
   typedef enum logic [1:0] {
      AT_LEAST = 2'b00,
      EXACTLY  = 2'b01,
      ALL      = 2'b10,
      ODD      = 2'b11
   } mode_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int cntw(input int grid);
      return $clog2(grid * grid + 1);
   endfunction

   function automatic int kw(input int nc);
      return $clog2(nc + 1);
   endfunction

   // Circle 0 sits in the MSBs of the packed central/radius buses.
   function automatic int cen_msb(input int nc, input int cw, input int i);
      return (nc - i) * 2 * cw - 1;
   endfunction

   function automatic int rad_msb(input int nc, input int cw, input int i);
      return (nc - i) * cw - 1;
   endfunction
endpackage

// File: rtl/set_region_counter_if.sv
// Job request / result bundle between the issue logic and the counter.
interface set_region_counter_if import set_pkg::*; #(
   parameter int GRID = 8,
   parameter int NC   = 3,
   parameter int CW   = 4
);
   localparam int KW   = kw(NC);
   localparam int CNTW = cntw(GRID);

   logic                 en;
   logic [2*CW*NC-1:0]   central;
   logic [CW*NC-1:0]     radius;
   logic [NC-1:0]        mask;
   logic [1:0]           mode;
   logic [KW-1:0]        k;
   logic                 busy;
   logic                 valid;
   logic [CNTW-1:0]      candidate;

   modport master (output en, central, radius, mask, mode, k,
                   input  busy, valid, candidate);
   modport slave  (input  en, central, radius, mask, mode, k,
                   output busy, valid, candidate);
endinterface

// File: rtl/set_region_counter_circle.sv
// One circle's S1 (abs-diff) and S2 (square-sum compare, masked hit) stages.
module set_circle_test #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] x,
   input  logic [CW-1:0] y,
   input  logic [CW-1:0] xc,
   input  logic [CW-1:0] yc,
   input  logic [CW-1:0] r,
   input  logic          enable,
   output logic          hit
);
   localparam int SW = 2 * CW + 1;

   logic [CW-1:0] dx, dy;
   logic [SW-1:0] dxe, dye, re, sum, rsq;

   // Full 2CW+1 width keeps dx^2+dy^2 exact for any centre, inside or not.
   assign dxe = SW'(dx);
   assign dye = SW'(dy);
   assign re  = SW'(r);
   assign sum = dxe * dxe + dye * dye;
   assign rsq = re * re;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dx  <= '0;
         dy  <= '0;
         hit <= 1'b0;
      end else begin
         dx  <= (x >= xc) ? x - xc : xc - x;
         dy  <= (y >= yc) ? y - yc : yc - y;
         hit <= enable && (sum <= rsq);
      end
   end
endmodule

// File: rtl/set_region_counter.sv
// Grid-coverage counter: scans GRID x GRID points, counts those meeting the job's rule.
module set_region_counter import set_pkg::*; #(
   parameter int GRID = 8,
   parameter int NC   = 3,
   parameter int CW   = 4
) (
   input  logic               clk,
   input  logic               rst,
   set_region_counter_if.slave bus
);
   localparam int KW   = kw(NC);
   localparam int CNTW = cntw(GRID);
   localparam logic [CW-1:0] GMAX = CW'(GRID);

   logic [1:0]          state;
   logic [2*CW*NC-1:0]  j_cen;
   logic [CW*NC-1:0]    j_rad;
   logic [NC-1:0]       j_mask;
   mode_t               j_mode;
   logic [KW-1:0]       j_k;
   logic [CW-1:0]       x, y;
   logic                drain_cnt;
   logic [1:0]          vld_pipe;
   logic [NC-1:0]       hit;
   logic [KW-1:0]       n;
   logic                rule_ok;
   logic [CNTW-1:0]     acc, cand;
   logic                valid_q;

   for (genvar i = 0; i < NC; i++) begin : g_circ
      set_circle_test #(.CW(CW)) u_circ (
         .clk    (clk),
         .rst    (rst),
         .x      (x),
         .y      (y),
         .xc     (j_cen[cen_msb(NC, CW, i) -: CW]),
         .yc     (j_cen[cen_msb(NC, CW, i) - CW -: CW]),
         .r      (j_rad[rad_msb(NC, CW, i) -: CW]),
         .enable (j_mask[i]),
         .hit    (hit[i])
      );
   end

   always_comb begin
      n = '0;
      for (int i = 0; i < NC; i++) n = n + KW'(hit[i]);
   end

   always_comb begin
      rule_ok = 1'b0;
      case (j_mode)
         AT_LEAST: rule_ok = (n >= j_k);
         EXACTLY:  rule_ok = (n == j_k);
         ALL:      rule_ok = (hit == j_mask) && (|j_mask);
         ODD:      rule_ok = n[0];
         default:  rule_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         j_cen     <= '0;
         j_rad     <= '0;
         j_mask    <= '0;
         j_mode    <= AT_LEAST;
         j_k       <= '0;
         x         <= '0;
         y         <= '0;
         drain_cnt <= 1'b0;
         vld_pipe  <= '0;
         acc       <= '0;
         cand      <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q  <= 1'b0;
         // vld_pipe[0]: point held in S1, vld_pipe[1]: hit vector valid in S2
         vld_pipe <= {vld_pipe[0], state == ST_SCAN};
         if (vld_pipe[1] && rule_ok) acc <= acc + CNTW'(1);

         case (state)
            ST_IDLE: begin
               if (bus.en) begin
                  j_cen  <= bus.central;
                  j_rad  <= bus.radius;
                  j_mask <= bus.mask;
                  j_mode <= mode_t'(bus.mode);
                  j_k    <= bus.k;
                  acc    <= '0;
                  cand   <= '0;
                  x      <= CW'(1);
                  y      <= CW'(1);
                  state  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (x == GMAX) begin
                  x <= CW'(1);
                  if (y == GMAX) begin
                     drain_cnt <= 1'b0;
                     state     <= ST_DRAIN;
                  end else begin
                     y <= y + CW'(1);
                  end
               end else begin
                  x <= x + CW'(1);
               end
            end
            ST_DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) state <= ST_DONE;
            end
            default: begin
               cand    <= acc;
               valid_q <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = (state != ST_IDLE);
   assign bus.valid     = valid_q;
   assign bus.candidate = cand;
endmodule

// File: tb/tb_set_region_counter.sv
// Bench for set_region_counter: geometric reference model, per-cycle compare, directed and random jobs.
module tb_set_region_counter;
   localparam int GRID = 8;
   localparam int NC   = 3;
   localparam int CW   = 4;
   localparam int LAT  = GRID * GRID + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   started = 1'b0;
   int   checks = 0;
   int   failures = 0;

   set_region_counter_if #(.GRID(GRID), .NC(NC), .CW(CW)) bus ();

   set_region_counter #(.GRID(GRID), .NC(NC), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // Count lattice points satisfying the rule, straight from the geometry.
   function automatic int ref_count(input logic [23:0] c, input logic [11:0] r,
                                    input logic [2:0] m, input logic [1:0] md,
                                    input logic [1:0] kk);
      int total = 0;
      for (int py = 1; py <= GRID; py++) begin
         for (int px = 1; px <= GRID; px++) begin
            int  nh = 0;
            bit  all_hit = 1'b1;
            bit  ok;
            for (int i = 0; i < NC; i++) begin
               int cx, cy, rr;
               bit h;
               cx = int'(c[(NC-1-i)*8+4 +: 4]);
               cy = int'(c[(NC-1-i)*8 +: 4]);
               rr = int'(r[(NC-1-i)*4 +: 4]);
               h  = m[i] && ((px-cx)*(px-cx) + (py-cy)*(py-cy) <= rr*rr);
               if (h) nh++;
               if (m[i] && !h) all_hit = 1'b0;
            end
            case (md)
               2'd0:    ok = (nh >= int'(kk));
               2'd1:    ok = (nh == int'(kk));
               2'd2:    ok = all_hit && (m != 3'b000);
               default: ok = (nh % 2) == 1;
            endcase
            if (ok) total++;
         end
      end
      return total;
   endfunction

   // Expected output timeline: job accepted in idle, result LAT edges later.
   bit m_busy, m_valid;
   int m_cand, m_res, m_cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_valid = 0; m_cand = 0; m_res = 0; m_cyc = 0;
      end else if (m_busy) begin
         m_cyc++;
         if (m_cyc == LAT) begin
            m_busy = 0; m_valid = 1; m_cand = m_res;
         end
      end else begin
         m_valid = 0;
         if (bus.en) begin
            m_busy = 1; m_cyc = 0; m_cand = 0;
            m_res  = ref_count(bus.central, bus.radius, bus.mask, bus.mode, bus.k);
         end
      end
   end

   always @(negedge clk) begin
      if (started && !rst) begin
         chk("cyc_busy", int'(bus.busy), int'(m_busy));
         chk("cyc_valid", int'(bus.valid), int'(m_valid));
         chk("cyc_candidate", int'(bus.candidate), m_cand);
      end
   end

   task automatic drive(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m,
                        input logic [1:0] md, input logic [1:0] kk);
      bus.central = c; bus.radius = r; bus.mask = m; bus.mode = md; bus.k = kk;
   endtask

   // Called #1 after an edge; en is sampled at the next edge (E0).
   task automatic start_job(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m,
                            input logic [1:0] md, input logic [1:0] kk);
      drive(c, r, m, md, kk);
      bus.en = 1'b1;
      @(posedge clk); #1;
      bus.en = 1'b0;
      drive(24'($urandom), 12'($urandom), 3'($urandom), 2'($urandom), 2'($urandom));
   endtask

   task automatic wait_done(input bit pulse, output int cnt, output int lat);
      lat = -1;
      for (int nn = 1; nn <= 200; nn++) begin
         @(posedge clk); #1;
         if (pulse && (nn == 9 || nn == 39)) begin
            drive(24'h11_00_00, 12'h300, 3'b111, 2'b00, 2'd0);
            bus.en = 1'b1;
         end else if (pulse && (nn == 10 || nn == 40)) begin
            bus.en = 1'b0;
         end
         if (bus.valid) begin
            lat = nn;
            break;
         end
      end
      cnt = int'(bus.candidate);
   endtask

   task automatic directed(input string name, input logic [23:0] c, input logic [11:0] r,
                           input logic [2:0] m, input logic [1:0] md, input logic [1:0] kk,
                           input int exp);
      int cnt, lat;
      chk({name, "_model"}, ref_count(c, r, m, md, kk), exp);
      start_job(c, r, m, md, kk);
      wait_done(1'b0, cnt, lat);
      chk({name, "_count"}, cnt, exp);
      chk({name, "_latency"}, lat, LAT);
   endtask

   localparam logic [23:0] C44   = 24'h44_00_00;
   localparam logic [23:0] C4454 = 24'h44_54_00;
   localparam logic [23:0] C11   = 24'h11_00_00;

   initial begin
      int cnt, lat;
      logic [23:0] rc;
      logic [11:0] rr;
      logic [2:0]  rm;
      logic [1:0]  rmd, rk;
      int exp;

      bus.en = 1'b0;
      drive('0, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_valid", int'(bus.valid), 0);
      chk("reset_candidate", int'(bus.candidate), 0);
      rst = 1'b0;
      started = 1'b1;
      @(posedge clk); #1;

      directed("atleast_single", C44,   12'h200, 3'b001, 2'd0, 2'd1, 13);
      @(posedge clk); #1;
      chk("valid_one_cycle", int'(bus.valid), 0);
      chk("candidate_hold", int'(bus.candidate), 13);
      directed("all_pair",     C4454, 12'h220, 3'b011, 2'd2, 2'd0, 8);
      directed("odd_pair",     C4454, 12'h220, 3'b011, 2'd3, 2'd0, 10);
      directed("exactly_pair", C4454, 12'h220, 3'b011, 2'd1, 2'd1, 10);
      directed("clip_corner",  C11,   12'h300, 3'b001, 2'd0, 2'd1, 11);
      directed("all_nomask",   C4454, 12'h220, 3'b000, 2'd2, 2'd0, 0);
      directed("atleast_k0",   C44,   12'h200, 3'b001, 2'd0, 2'd0, 64);
      directed("atleast_kmax", C4454, 12'h220, 3'b011, 2'd0, 2'd3, 0);

      // en pulses mid-job must be ignored; en right after valid starts a new job
      start_job(C44, 12'h200, 3'b001, 2'd0, 2'd1);
      wait_done(1'b1, cnt, lat);
      chk("ignore_en_count", cnt, 13);
      chk("ignore_en_latency", lat, LAT);
      start_job(C11, 12'h300, 3'b001, 2'd0, 2'd1);
      chk("restart_cleared", int'(bus.candidate), 0);
      chk("restart_busy", int'(bus.busy), 1);
      wait_done(1'b0, cnt, lat);
      chk("restart_count", cnt, 11);
      chk("restart_latency", lat, LAT);

      // asynchronous reset in the middle of a job
      start_job(C4454, 12'h220, 3'b011, 2'd3, 2'd0);
      repeat (29) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_valid", int'(bus.valid), 0);
      chk("midrst_candidate", int'(bus.candidate), 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      start_job(C11, 12'h300, 3'b001, 2'd0, 2'd1);
      wait_done(1'b0, cnt, lat);
      chk("after_rst_count", cnt, 11);
      chk("after_rst_latency", lat, LAT);

      for (int j = 0; j < 200; j++) begin
         rc  = 24'($urandom);
         rr  = 12'($urandom);
         rm  = 3'($urandom);
         rmd = 2'($urandom);
         rk  = 2'($urandom);
         exp = ref_count(rc, rr, rm, rmd, rk);
         start_job(rc, rr, rm, rmd, rk);
         wait_done(1'b0, cnt, lat);
         chk("rand_count", cnt, exp);
         chk("rand_latency", lat, LAT);
      end

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
